// File: rtl/fleet_placer_if.sv
// Bundle that connects the fleet placer to the player input, the validator and board memory.
// The master side is the surrounding game logic; the slave side is the placer.
interface fleet_placer_if #(
  parameter int COORD_W = 4
);
  logic               enable;
  logic               enter;
  logic               select;
  logic               mode;
  logic               val_done;
  logic               conflito;
  logic               valida;
  logic               grava;
  logic [2:0]         tipo;
  logic               jogador;
  logic [COORD_W-1:0] X1;
  logic [COORD_W-1:0] Y1;
  logic               direcao;
  logic [2:0]         orientacao;
  logic [5:0]         estado;
  logic               ready;

  modport master (
    output enable, enter, select, mode, val_done, conflito,
    input  valida, grava, tipo, jogador, X1, Y1, direcao, orientacao, estado, ready
  );

  modport slave (
    input  enable, enter, select, mode, val_done, conflito,
    output valida, grava, tipo, jogador, X1, Y1, direcao, orientacao, estado, ready
  );
endinterface

// File: rtl/fleet_placer.sv
// Ship-placement controller for Batalha Naval: steps each player through direction,
// orientation, X and Y for every ship, asks the validator for a conflict check and
// writes accepted ships to board memory. Raises ready once all fleets are placed.
module fleet_placer #(
  parameter int          BOARD    = 10,
  parameter int          COORD_W  = 4,
  parameter int          N_TYPES  = 5,
  parameter logic [31:0] COUNTS   = 32'h0001_1225,
  parameter int          N_ORIENT = 5
) (
  input logic           clk,
  input logic           reset,
  fleet_placer_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DIR    = 3'd1;
  localparam logic [2:0] S_ORIENT = 3'd2;
  localparam logic [2:0] S_DEF_X  = 3'd3;
  localparam logic [2:0] S_DEF_Y  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_STORE  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [COORD_W-1:0] COORD_MAX  = COORD_W'(BOARD - 1);
  localparam logic [2:0]         ORIENT_MAX = 3'(N_ORIENT - 1);

  logic [2:0]         state_reg;
  logic [3:0]         ship_cnt_reg;
  logic [2:0]         tipo_reg;
  logic               jogador_reg;
  logic               mode_reg;
  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic               direcao_reg;
  logic [2:0]         orient_reg;

  logic [3:0] cnt_of [N_TYPES];
  logic [3:0] cur_cnt;
  logic [2:0] tipo_next;
  logic       tipo_next_valid;
  logic       type_done;

  // Unpack the per-type ship counts.
  for (genvar gi = 0; gi < N_TYPES; gi++) begin : g_counts
    assign cnt_of[gi] = COUNTS[4*gi +: 4];
  end

  // Find the count of the current type and the next type with a non-zero count.
  always_comb begin
    cur_cnt         = 4'd0;
    tipo_next       = tipo_reg;
    tipo_next_valid = 1'b0;
    for (int t = N_TYPES - 1; t >= 0; t--) begin
      if (3'(t) == tipo_reg) begin
        cur_cnt = cnt_of[t];
      end
      if (3'(t) > tipo_reg && cnt_of[t] != 4'd0) begin
        tipo_next       = 3'(t);
        tipo_next_valid = 1'b1;
      end
    end
  end

  // A zero-count current type is treated as complete after one store so it never stalls.
  assign type_done = ({1'b0, ship_cnt_reg} + 5'd1) >= {1'b0, cur_cnt};

  // Placement state machine and field registers; enable low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      ship_cnt_reg <= 4'd0;
      tipo_reg     <= 3'd0;
      jogador_reg  <= 1'b0;
      mode_reg     <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      direcao_reg  <= 1'b0;
      orient_reg   <= 3'd0;
    end else if (bus.enable) begin
      case (state_reg)
        S_IDLE: begin
          mode_reg  <= bus.mode;
          state_reg <= S_DIR;
        end
        S_DIR: begin
          if (bus.enter)       state_reg   <= S_ORIENT;
          else if (bus.select) direcao_reg <= ~direcao_reg;
        end
        S_ORIENT: begin
          if (bus.enter)       state_reg  <= S_DEF_X;
          else if (bus.select) orient_reg <= (orient_reg == ORIENT_MAX) ? 3'd0 : orient_reg + 3'd1;
        end
        S_DEF_X: begin
          if (bus.enter)       state_reg <= S_DEF_Y;
          else if (bus.select) x_reg     <= (x_reg == COORD_MAX) ? '0 : x_reg + 1'b1;
        end
        S_DEF_Y: begin
          if (bus.enter)       state_reg <= S_CHECK;
          else if (bus.select) y_reg     <= (y_reg == COORD_MAX) ? '0 : y_reg + 1'b1;
        end
        S_CHECK: begin
          if (bus.val_done) state_reg <= bus.conflito ? S_DEF_X : S_STORE;
        end
        S_STORE: begin
          state_reg <= S_DIR;
          if (!type_done) begin
            ship_cnt_reg <= ship_cnt_reg + 4'd1;
          end else begin
            ship_cnt_reg <= 4'd0;
            if (tipo_next_valid) begin
              tipo_reg <= tipo_next;
            end else if (!jogador_reg && mode_reg) begin
              jogador_reg <= 1'b1;
              tipo_reg    <= 3'd0;
            end else begin
              state_reg <= S_DONE;
            end
          end
        end
        default: state_reg <= state_reg;
      endcase
    end
  end

  // One-hot state indication: bit gi marks state code gi+1 (DIR..STORE).
  for (genvar gi = 0; gi < 6; gi++) begin : g_estado
    assign bus.estado[gi] = (state_reg == 3'(gi + 1));
  end

  assign bus.valida     = (state_reg == S_CHECK);
  assign bus.grava      = (state_reg == S_STORE);
  assign bus.ready      = (state_reg == S_DONE);
  assign bus.tipo       = tipo_reg;
  assign bus.jogador    = jogador_reg;
  assign bus.X1         = x_reg;
  assign bus.Y1         = y_reg;
  assign bus.direcao    = direcao_reg;
  assign bus.orientacao = orient_reg;

endmodule

// File: tb/tb_fleet_placer.sv
// Directed bench for fleet_placer: walks the placement flow, wrap-arounds, conflicts,
// both game modes, freeze, DONE lock-out and asynchronous reset.
module tb_fleet_placer;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  fleet_placer_if #(.COORD_W(4)) bus ();

  fleet_placer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ship type expected at each of the 11 stores of one fleet.
  int exp_types [11] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3, 4};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_enter();
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
  endtask

  task automatic press_select();
    bus.select = 1'b1;
    tick();
    bus.select = 1'b0;
  endtask

  task automatic pulse_val(input logic c);
    bus.val_done = 1'b1;
    bus.conflito = c;
    tick();
    bus.val_done = 1'b0;
    bus.conflito = 1'b0;
  endtask

  // From DIR: walk to CHECK, accept, check the store cycle, return to DIR/DONE.
  task automatic place_ship(input int exp_tipo, input logic exp_jog);
    repeat (4) press_enter();
    chk("check_state", bus.estado, 6'b010000);
    pulse_val(1'b0);
    chk("store_grava", bus.grava, 1'b1);
    chk("store_tipo", bus.tipo, exp_tipo);
    chk("store_jogador", bus.jogador, exp_jog);
    tick();
    chk("post_store_grava", bus.grava, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset        = 1'b0;
    bus.enable   = 1'b0;
    bus.enter    = 1'b0;
    bus.select   = 1'b0;
    bus.mode     = 1'b0;
    bus.val_done = 1'b0;
    bus.conflito = 1'b0;

    // Reset state
    tick();
    reset = 1'b1;
    chk("rst_estado", bus.estado, 6'b000000);
    chk("rst_valida", bus.valida, 1'b0);
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_grava", bus.grava, 1'b0);
    chk("rst_x1", bus.X1, 4'd0);
    chk("rst_tipo", bus.tipo, 3'd0);
    tick();
    chk("idle_hold_disabled", bus.estado, 6'b000000);

    // IDLE -> DIR, direction toggle
    bus.enable = 1'b1;
    tick();
    chk("dir_state", bus.estado, 6'b000001);
    press_select();
    chk("dir_toggle", bus.direcao, 1'b1);
    press_enter();
    chk("orient_state", bus.estado, 6'b000010);

    // Orientation wraps at N_ORIENT-1
    for (int i = 0; i < 6; i++) begin
      press_select();
      chk("orient_sel", bus.orientacao, (i + 1) % 5);
    end
    press_enter();
    chk("defx_state", bus.estado, 6'b000100);

    // X wraps at BOARD-1
    for (int i = 0; i < 11; i++) begin
      press_select();
      chk("x_sel", bus.X1, (i + 1) % 10);
    end
    press_enter();
    chk("defy_state", bus.estado, 6'b001000);
    repeat (3) press_select();
    chk("y_sel", bus.Y1, 4'd3);

    // enter + select together: enter wins
    bus.enter  = 1'b1;
    bus.select = 1'b1;
    tick();
    bus.enter  = 1'b0;
    bus.select = 1'b0;
    chk("both_state", bus.estado, 6'b010000);
    chk("both_y", bus.Y1, 4'd3);
    chk("check_valida", bus.valida, 1'b1);
    chk("check_tipo", bus.tipo, 3'd0);
    chk("check_jog", bus.jogador, 1'b0);

    // enter ignored in CHECK
    press_enter();
    chk("check_enter_ign", bus.estado, 6'b010000);

    // Conflict -> back to DEF_X, coordinates kept
    pulse_val(1'b1);
    chk("conf_state", bus.estado, 6'b000100);
    chk("conf_x", bus.X1, 4'd1);
    chk("conf_y", bus.Y1, 4'd3);
    chk("conf_grava", bus.grava, 1'b0);
    chk("conf_valida", bus.valida, 1'b0);
    press_enter();
    press_enter();
    chk("recheck_state", bus.estado, 6'b010000);

    // Freeze: val_done lost, valida held
    bus.enable = 1'b0;
    pulse_val(1'b0);
    chk("freeze_state", bus.estado, 6'b010000);
    chk("freeze_valida", bus.valida, 1'b1);
    bus.enable = 1'b1;

    // Accept: single-cycle grava then DIR
    pulse_val(1'b0);
    chk("acc_grava", bus.grava, 1'b1);
    chk("acc_estado", bus.estado, 6'b100000);
    tick();
    chk("acc_grava_off", bus.grava, 1'b0);
    chk("acc_dir", bus.estado, 6'b000001);

    // Rest of the single-player fleet
    for (int k = 1; k < 11; k++) place_ship(exp_types[k], 1'b0);
    chk("pvc_ready", bus.ready, 1'b1);
    chk("pvc_estado", bus.estado, 6'b000000);
    chk("pvc_jog", bus.jogador, 1'b0);
    chk("retain_x", bus.X1, 4'd1);
    chk("retain_dir", bus.direcao, 1'b1);

    // Inputs ignored in DONE
    press_select();
    press_enter();
    pulse_val(1'b0);
    chk("done_ready", bus.ready, 1'b1);
    chk("done_x", bus.X1, 4'd1);
    chk("done_grava", bus.grava, 1'b0);

    // Player vs Player
    reset = 1'b0;
    #1;
    chk("rst2_ready", bus.ready, 1'b0);
    bus.mode = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("pvp_dir", bus.estado, 6'b000001);
    bus.mode = 1'b0;
    for (int k = 0; k < 11; k++) place_ship(exp_types[k], 1'b0);
    chk("pvp_switch_state", bus.estado, 6'b000001);
    chk("pvp_switch_jog", bus.jogador, 1'b1);
    chk("pvp_switch_tipo", bus.tipo, 3'd0);
    chk("pvp_switch_ready", bus.ready, 1'b0);
    for (int k = 0; k < 11; k++) place_ship(exp_types[k], 1'b1);
    chk("pvp_ready", bus.ready, 1'b1);
    press_enter();
    press_select();
    chk("pvp_done_ready", bus.ready, 1'b1);
    chk("pvp_done_estado", bus.estado, 6'b000000);

    // Asynchronous reset in the middle of CHECK
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    repeat (4) press_enter();
    chk("pre_arst_valida", bus.valida, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valida", bus.valida, 1'b0);
    chk("arst_estado", bus.estado, 6'b000000);
    chk("arst_y", bus.Y1, 4'd0);
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
